ddr2_cmd_sched: RTL
===================

DDR2_CMD_SCHED -- requirements
Module: ddr2_cmd_sched

Interface
REQ-001 Parameter T_RP, default 3, PRE-to-next-command spacing in ck cycles.
REQ-002 Parameter T_RCD, default 3, ACT-to-RD/WR spacing in ck cycles.
REQ-003 Parameter T_RFC, default 26, REF-to-next-command spacing in ck cycles.
REQ-004 Parameter T_AP, default 8, RDA/WRA-to-next-command spacing in ck cycles (burst plus auto-precharge recovery).
REQ-005 ck  in  1  controller clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset: asynchronous, active-low.
REQ-007 init_end  in  1  level; high once power-up initialisation is complete.
REQ-008 aref_req  in  1  refresh request, held until aref_ack.
REQ-009 aref_ack  out  1  one-cycle pulse; refresh accepted.
REQ-010 wr_req / rd_req  in  1 each  access requests, held until own ack.
REQ-011 wr_ack / rd_ack  out  1 each  one-cycle pulse in the cycle the WRA/RDA command is driven.
REQ-012 wr_ba, rd_ba  in  3  target bank; wr_row, rd_row  in  13; wr_col, rd_col  in  10; all stable while the matching req is high.
REQ-013 cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRE 0010, REF 0001, ACT 0011, WRA 0100, RDA 0101.
REQ-014 ba  out  3; addr  out  13; command bank/address.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 cmd, ba, addr, acks SHALL be registered; each non-NOP command SHALL occupy exactly one cycle; all other cycles SHALL drive NOP, ba=0, addr=0.
REQ-017 States: WAIT_INIT, IDLE, PRE, TRP, REF, TRFC, ACT, TRCD, RW, TAP; WAIT_INIT->IDLE on the first cycle init_end is sampled high.
REQ-018 In WAIT_INIT all requests SHALL be ignored and no ack issued.
REQ-019 IDLE arbitration: aref_req highest; otherwise write/read per REQ-031/032; a grant decided in cycle c SHALL drive its first command at c+1.
REQ-020 Refresh: PRE with addr=0x0400 (A10=1, all banks), aref_ack with PRE; REF exactly T_RP cycles after PRE; return to IDLE so the next command is no earlier than REF+T_RFC.
REQ-021 Access: ACT with ba=bank, addr=row; RDA/WRA exactly T_RCD cycles after ACT with ba=bank, addr={2'b00,1'b1,col}; next command no earlier than RDA/WRA+T_AP.
REQ-022 Bank/row/col SHALL be captured at the grant; later input changes SHALL not affect the access in flight.
REQ-023 aref_req rising during an access SHALL wait until that access completes, then win over any pending rd/wr.
REQ-024 Simultaneous aref_req, wr_req, rd_req in IDLE: refresh first, then the rd/wr winner, then the other; none lost.
REQ-025 Timer SHALL be a down-counter sized for max(T_RFC,T_AP) plus 1 bit; parameters of 1 SHALL give back-to-back spacing with no extra cycle.
REQ-026 A request deasserted before its ack (protocol violation) SHALL, if not yet granted, be dropped; if granted, the access SHALL complete.

Reset
REQ-027 rst_n low SHALL immediately force state WAIT_INIT, cmd=NOP, ba=0, addr=0, all acks 0, busy=1, timer 0, round-robin pointer to write.
REQ-028 Reset mid-access or mid-refresh SHALL abort with no further command; after release the block SHALL wait for init_end again.
REQ-029 Reset release SHALL be used synchronously to ck (no command in the release cycle).
REQ-030 busy SHALL be high from reset until IDLE is entered.

Configuration
REQ-031 Macro DDR2_SCHED_RR_EN defined: read/write SHALL alternate round-robin; the pointer toggles only on a granted access; the next access favours the other type.
REQ-032 Macro undefined: fixed priority, write over read; no pointer register.

Verification
REQ-033 Reset, init_end high at cycle 10, aref_req at 20 -> PRE addr 0x0400 at 22, aref_ack at 22, REF at 25, next command no earlier than 51.
REQ-034 Idle, wr_req ba=2 row=0x1ABC col=0x155 -> ACT ba=2 addr=0x1ABC, WRA 3 cycles later addr=0x0555 with wr_ack, busy until WRA+8.
REQ-035 wr_req and rd_req held together, DDR2_SCHED_RR_EN defined -> order WRA, RDA, WRA, RDA; undefined -> WRA only while wr_req held.
REQ-036 aref_req asserted 1 cycle after ACT -> RDA completes normally, then PRE-all precedes any further ACT.
REQ-037 rst_n low 1 cycle after ACT -> cmd NOP immediately, no RDA/WRA, no ack; after release and init_end, pending rd_req is served from ACT.
REQ-038 All three requests in same IDLE cycle -> PRE/REF first, then rd/wr in arbitration order, each acked exactly once.

Source files
------------

// File: rtl/ddr2_cmd_sched.sv
// DDR2 command scheduler: arbitrates refresh, write and read requests and
// sequences PRE/REF or ACT/WRA/RDA with down-counter spacing timers.
// Optional build macro DDR2_SCHED_RR_EN: read/write round-robin arbitration.
// Without it, writes have fixed priority over reads.
//
// state     | meaning
// WAIT_INIT | after reset, waiting for init_end
// IDLE      | arbitrating refresh / write / read
// PRE       | precharge-all being issued (with aref_ack)
// TRP       | waiting out tRP before REF
// REF       | auto-refresh being issued
// TRFC      | waiting out tRFC
// ACT       | activate of captured bank/row being issued
// TRCD      | waiting out tRCD before the column command
// RW        | WRA/RDA being issued (with wr_ack/rd_ack)
// TAP       | waiting out burst plus auto-precharge recovery
module ddr2_cmd_sched #(
  parameter int T_RP  = 3,
  parameter int T_RCD = 3,
  parameter int T_RFC = 26,
  parameter int T_AP  = 8
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic        aref_req,
  output logic        aref_ack,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic [2:0]  wr_ba,
  input  logic [12:0] wr_row,
  input  logic [9:0]  wr_col,
  input  logic        rd_req,
  output logic        rd_ack,
  input  logic [2:0]  rd_ba,
  input  logic [12:0] rd_row,
  input  logic [9:0]  rd_col,
  output logic [3:0]  cmd,
  output logic [2:0]  ba,
  output logic [12:0] addr,
  output logic        busy
);

  localparam int T_MAX = (T_RFC > T_AP) ? T_RFC : T_AP;
  localparam int TW    = $clog2(T_MAX + 1) + 1;

  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WRA = 4'b0100;
  localparam logic [3:0] CMD_RDA = 4'b0101;

  localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;

  typedef enum logic [3:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_PRE,
    ST_TRP,
    ST_REF,
    ST_TRFC,
    ST_ACT,
    ST_TRCD,
    ST_RW,
    ST_TAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [2:0]    ba_q, ba_d;
  logic [12:0]   addr_q, addr_d;
  logic          aref_ack_q, aref_ack_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          acc_wr_q, acc_wr_d;
  logic [2:0]    acc_ba_q, acc_ba_d;
  logic [12:0]   acc_row_q, acc_row_d;
  logic [9:0]    acc_col_q, acc_col_d;
  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_int_n;
  logic          grant_wr;

  // Reset asserts at once but releases two ck edges later, so the release
  // edge can never launch a command.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Reset release synchroniser.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

`ifdef DDR2_SCHED_RR_EN
  // rr_q high means the next contested grant goes to the write port.
  logic rr_q, rr_d;

  // Round-robin pointer register.
  always_ff @(posedge ck or negedge rst_int_n) begin
    if (!rst_int_n) rr_q <= 1'b1;
    else            rr_q <= rr_d;
  end

  assign grant_wr = wr_req & (~rd_req | rr_q);
`else
  assign grant_wr = wr_req;
`endif

  // Next-state, timer and registered-output decode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cmd_d      = CMD_NOP;
    ba_d       = 3'd0;
    addr_d     = 13'd0;
    aref_ack_d = 1'b0;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    acc_wr_d   = acc_wr_q;
    acc_ba_d   = acc_ba_q;
    acc_row_d  = acc_row_q;
    acc_col_d  = acc_col_q;
`ifdef DDR2_SCHED_RR_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      ST_WAIT_INIT: begin
        if (init_end) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (aref_req) begin
          state_d = ST_PRE;
        end else if (wr_req | rd_req) begin
          state_d   = ST_ACT;
          acc_wr_d  = grant_wr;
          acc_ba_d  = grant_wr ? wr_ba  : rd_ba;
          acc_row_d = grant_wr ? wr_row : rd_row;
          acc_col_d = grant_wr ? wr_col : rd_col;
`ifdef DDR2_SCHED_RR_EN
          rr_d      = ~grant_wr;
`endif
        end
      end
      ST_PRE: begin
        cmd_d      = CMD_PRE;
        addr_d     = ADDR_ALL_BANKS;
        aref_ack_d = 1'b1;
        if (T_RP <= 1) begin
          state_d = ST_REF;
        end else begin
          state_d = ST_TRP;
          timer_d = TW'(T_RP - 1);
        end
      end
      ST_TRP: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q <= TMR_ONE) state_d = ST_REF;
      end
      ST_REF: begin
        cmd_d   = CMD_REF;
        state_d = ST_TRFC;
        timer_d = TW'(T_RFC);
      end
      ST_TRFC: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q <= TMR_ONE) state_d = ST_IDLE;
      end
      ST_ACT: begin
        cmd_d  = CMD_ACT;
        ba_d   = acc_ba_q;
        addr_d = acc_row_q;
        if (T_RCD <= 1) begin
          state_d = ST_RW;
        end else begin
          state_d = ST_TRCD;
          timer_d = TW'(T_RCD - 1);
        end
      end
      ST_TRCD: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q <= TMR_ONE) state_d = ST_RW;
      end
      ST_RW: begin
        cmd_d    = acc_wr_q ? CMD_WRA : CMD_RDA;
        ba_d     = acc_ba_q;
        addr_d   = {3'b001, acc_col_q};
        wr_ack_d = acc_wr_q;
        rd_ack_d = ~acc_wr_q;
        state_d  = ST_TAP;
        timer_d  = TW'(T_AP);
      end
      ST_TAP: begin
        timer_d = timer_q - TMR_ONE;
        if (timer_q <= TMR_ONE) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_WAIT_INIT;
        timer_d = '0;
      end
    endcase
  end

  // State, timer, captured access and output registers.
  always_ff @(posedge ck or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= ST_WAIT_INIT;
      timer_q    <= '0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 3'd0;
      addr_q     <= 13'd0;
      aref_ack_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      acc_wr_q   <= 1'b0;
      acc_ba_q   <= 3'd0;
      acc_row_q  <= 13'd0;
      acc_col_q  <= 10'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      aref_ack_q <= aref_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      acc_wr_q   <= acc_wr_d;
      acc_ba_q   <= acc_ba_d;
      acc_row_q  <= acc_row_d;
      acc_col_q  <= acc_col_d;
    end
  end

  assign cmd      = cmd_q;
  assign ba       = ba_q;
  assign addr     = addr_q;
  assign aref_ack = aref_ack_q;
  assign wr_ack   = wr_ack_q;
  assign rd_ack   = rd_ack_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
